// File: rtl/frac_divider.sv
// frac_divider: sequential radix-2 restoring divider with a left pre-shift on
// the dividend for fixed-point scaling. The operation takes 2*WIDTH ITER
// cycles plus one FIX cycle. A zero divisor is answered directly from IDLE.
//
// Handshake: the block accepts a request when once=1 while it is idle
// (busy=0). The operands are captured on that edge. done is high for exactly
// one cycle when out/rem/dz/ovf are updated. The outputs then hold until the
// next done pulse. A request made while busy=1 is dropped and is not queued.
module frac_divider #(
  parameter int WIDTH  = 16,
  parameter int SIGNED = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     once,
  input  logic [WIDTH-1:0]         in0,
  input  logic [WIDTH-1:0]         in1,
  input  logic [$clog2(WIDTH)-1:0] shift,
  output logic [WIDTH-1:0]         out,
  output logic [WIDTH-1:0]         rem,
  output logic                     done,
  output logic                     busy,
  output logic                     dz,
  output logic                     ovf,
  output logic [1:0]               state_dbg
);

  localparam int CW = $clog2(2*WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(2*WIDTH - 1);

  localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] U_MAX = {WIDTH{1'b1}};

  // Largest quotient magnitude that fits the result, widened to the numerator width
  localparam logic [2*WIDTH-1:0] LIM_U   = {{WIDTH{1'b0}}, U_MAX};
  localparam logic [2*WIDTH-1:0] LIM_POS = {{WIDTH{1'b0}}, S_MAX};
  localparam logic [2*WIDTH-1:0] LIM_NEG = {{WIDTH{1'b0}}, S_MIN};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   num_q;   // numerator bits shift out of the top, quotient bits shift in at the bottom
  logic [WIDTH-1:0]     r_q;     // partial remainder, always < divisor
  logic [WIDTH-1:0]     d_q;     // divisor magnitude
  logic [CW-1:0]        cnt;
  logic                 q_neg;
  logic                 r_neg;

  // Operand conditioning. -2^(W-1) maps to 2^(W-1), which still fits unsigned W bits.
  logic                 in0_neg, in1_neg;
  logic [WIDTH-1:0]     in0_mag, in1_mag;
  logic [2*WIDTH-1:0]   num_init;
  logic [WIDTH-1:0]     dz_val;

  // One restoring step and the final sign/saturation stage
  logic [WIDTH:0]       trial;
  logic                 q_bit;
  logic [WIDTH-1:0]     r_next;
  logic [2*WIDTH-1:0]   q_lim;
  logic                 sat;
  logic [WIDTH-1:0]     sat_val;
  logic [WIDTH-1:0]     q_res;
  logic [WIDTH-1:0]     r_res;

  // Input magnitudes, the pre-shifted numerator and the divide-by-zero result
  always_comb begin
    in0_neg  = (SIGNED != 0) && in0[WIDTH-1];
    in1_neg  = (SIGNED != 0) && in1[WIDTH-1];
    in0_mag  = in0_neg ? (-in0) : in0;
    in1_mag  = in1_neg ? (-in1) : in1;
    num_init = {{WIDTH{1'b0}}, in0_mag} << shift;
    if (SIGNED != 0) dz_val = in0_neg ? S_MIN : S_MAX;
    else             dz_val = U_MAX;
  end

  // Restoring step plus the saturation and sign fix-up applied in FIX
  always_comb begin
    trial  = {r_q, num_q[2*WIDTH-1]};
    q_bit  = (trial >= {1'b0, d_q});
    // The true difference is below d_q, so W-bit wraparound arithmetic is exact
    r_next = q_bit ? (trial[WIDTH-1:0] - d_q) : trial[WIDTH-1:0];

    if (SIGNED != 0) q_lim = q_neg ? LIM_NEG : LIM_POS;
    else             q_lim = LIM_U;
    sat = (num_q > q_lim);

    if (SIGNED != 0) sat_val = q_neg ? S_MIN : S_MAX;
    else             sat_val = U_MAX;

    q_res = q_neg ? (-num_q[WIDTH-1:0]) : num_q[WIDTH-1:0];
    r_res = r_neg ? (-r_q) : r_q;
  end

  // Control FSM, datapath registers and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out   <= '0;
      rem   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
      dz    <= 1'b0;
      ovf   <= 1'b0;
      num_q <= '0;
      r_q   <= '0;
      d_q   <= '0;
      cnt   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (once) begin
            if (in1 == '0) begin
              out  <= dz_val;
              rem  <= '0;
              dz   <= 1'b1;
              ovf  <= 1'b0;
              done <= 1'b1;
            end else begin
              d_q   <= in1_mag;
              num_q <= num_init;
              r_q   <= '0;
              cnt   <= '0;
              q_neg <= in0_neg ^ in1_neg;
              r_neg <= in0_neg;
              busy  <= 1'b1;
              state <= ITER;
            end
          end
        end
        ITER: begin
          num_q <= {num_q[2*WIDTH-2:0], q_bit};
          r_q   <= r_next;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_ITER) state <= FIX;
        end
        FIX: begin
          if (sat) begin
            out <= sat_val;
            rem <= '0;
            ovf <= 1'b1;
          end else begin
            out <= q_res;
            rem <= r_res;
            ovf <= 1'b0;
          end
          dz    <= 1'b0;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_frac_divider.sv
// Testbench for frac_divider. It instantiates a signed and an unsigned
// instance, both WIDTH=16. Expected results come from an integer reference
// model and go into a queue. The monitor pops one entry per done pulse.
module tb_frac_divider;

  localparam int W   = 16;
  localparam int LAT = 2*W + 1;

  typedef struct packed {
    logic        sel;
    logic [15:0] out;
    logic [15:0] rem;
    logic        dz;
    logic        ovf;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        once_v  [2];
  logic [15:0] in0_v   [2];
  logic [15:0] in1_v   [2];
  logic [3:0]  shift_v [2];
  logic [15:0] out_v   [2];
  logic [15:0] rem_v   [2];
  logic        done_v  [2];
  logic        busy_v  [2];
  logic        dz_v    [2];
  logic        ovf_v   [2];
  logic [1:0]  st_v    [2];

  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  frac_divider #(.WIDTH(W), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .once(once_v[0]), .in0(in0_v[0]), .in1(in1_v[0]),
    .shift(shift_v[0]), .out(out_v[0]), .rem(rem_v[0]), .done(done_v[0]),
    .busy(busy_v[0]), .dz(dz_v[0]), .ovf(ovf_v[0]), .state_dbg(st_v[0])
  );

  frac_divider #(.WIDTH(W), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .once(once_v[1]), .in0(in0_v[1]), .in1(in1_v[1]),
    .shift(shift_v[1]), .out(out_v[1]), .rem(rem_v[1]), .done(done_v[1]),
    .busy(busy_v[1]), .dz(dz_v[1]), .ovf(ovf_v[1]), .state_dbg(st_v[1])
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer division on magnitudes, then sign and range rules
  function automatic exp_t model(input bit sel, input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] sh);
    exp_t        e;
    longint      av, bv, am, bm, n, q, r, lim;
    bit          sgn, neg;
    logic [63:0] t;
    e     = '0;
    e.sel = sel;
    sgn   = (sel == 1'b0);
    av    = sgn ? longint'($signed(a)) : longint'(a);
    bv    = sgn ? longint'($signed(b)) : longint'(b);
    am    = (av < 0) ? -av : av;
    bm    = (bv < 0) ? -bv : bv;
    if (bv == 0) begin
      e.dz  = 1'b1;
      e.out = sgn ? ((av < 0) ? 16'h8000 : 16'h7fff) : 16'hffff;
      e.rem = 16'h0000;
    end else begin
      n   = am * (longint'(1) << sh);
      q   = n / bm;
      r   = n % bm;
      neg = sgn && ((av < 0) != (bv < 0));
      lim = sgn ? (neg ? 32768 : 32767) : 65535;
      if (q > lim) begin
        e.ovf = 1'b1;
        e.out = sgn ? (neg ? 16'h8000 : 16'h7fff) : 16'hffff;
        e.rem = 16'h0000;
      end else begin
        t     = neg ? -q : q;
        e.out = t[15:0];
        t     = (av < 0) ? -r : r;
        e.rem = t[15:0];
      end
    end
    return e;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (done_v[k]) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: dut %0d pulsed done with nothing outstanding", k);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_dut_sel", k, mon_e.sel);
          check("out", out_v[k], mon_e.out);
          check("rem", rem_v[k], mon_e.rem);
          check("dz", dz_v[k], mon_e.dz);
          check("ovf", ovf_v[k], mon_e.ovf);
          check("latency_cycle", cyc, mon_e.cyc);
          check("busy_at_done", busy_v[k], 0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge. Presents a request for one cycle, then scrambles the inputs.
  task automatic issue(input bit sel, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] sh);
    exp_t e;
    once_v[sel]  = 1'b1;
    in0_v[sel]   = a;
    in1_v[sel]   = b;
    shift_v[sel] = sh;
    @(posedge clk);
    #1;
    once_v[sel]  = 1'b0;
    in0_v[sel]   = 16'($urandom);
    in1_v[sel]   = 16'($urandom);
    shift_v[sel] = 4'($urandom);
    e     = model(sel, a, b, sh);
    e.cyc = cyc + ((b == 16'h0) ? 0 : LAT);
    exp_q.push_back(e);
  endtask

  // Returns at the falling edge where a done pulse is visible
  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done_v[0] || done_v[1]) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: no done within 100 cycles, expected one");
    end
  endtask

  task automatic run(input bit sel, input logic [15:0] a, input logic [15:0] b,
                     input logic [3:0] sh);
    issue(sel, a, b, sh);
    wait_done();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        rs;
    logic [15:0] ra, rb;
    logic [3:0]  rsh;
    for (int k = 0; k < 2; k++) begin
      once_v[k] = 1'b0; in0_v[k] = '0; in1_v[k] = '0; shift_v[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("reset_out", out_v[k], 0);
      check("reset_rem", rem_v[k], 0);
      check("reset_flags", {done_v[k], busy_v[k], dz_v[k], ovf_v[k]}, 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed cases, with literal expectations on top of the model
    run(0, 16'd100, 16'd7, 4'd0);
    check("d100_7_out", out_v[0], 16'd14);
    check("d100_7_rem", rem_v[0], 16'd2);
    run(0, 16'hff9c, 16'd7, 4'd0);
    check("dm100_7_out", out_v[0], 16'hfff2);
    check("dm100_7_rem", rem_v[0], 16'hfffe);
    run(0, 16'd1, 16'd3, 4'd15);
    check("d1_3_s15_out", out_v[0], 16'h2aaa);
    check("d1_3_s15_rem", rem_v[0], 16'd2);
    run(0, 16'd5, 16'd0, 4'd0);
    check("dz_pos_out", out_v[0], 16'h7fff);
    check("dz_pos_flag", dz_v[0], 1);
    run(0, 16'hfffb, 16'd0, 4'd0);
    check("dz_neg_out", out_v[0], 16'h8000);
    run(0, 16'h4000, 16'd1, 4'd2);
    check("sat_out", out_v[0], 16'h7fff);
    check("sat_ovf", ovf_v[0], 1);
    run(0, 16'h8000, 16'd1, 4'd0);
    check("min_div1_out", out_v[0], 16'h8000);
    check("min_div1_ovf", ovf_v[0], 0);
    run(1, 16'hffff, 16'h0002, 4'd0);
    check("u_ffff_2_out", out_v[1], 16'h7fff);
    check("u_ffff_2_rem", rem_v[1], 16'd1);
    run(0, 16'h8000, 16'h8000, 4'd0);
    run(1, 16'h1234, 16'h0000, 4'd3);
    run(1, 16'h0003, 16'h0007, 4'd15);

    // A request made while busy must be dropped
    issue(0, 16'd1000, 16'd3, 4'd2);
    repeat (5) @(negedge clk);
    check("busy_mid_op", busy_v[0], 1);
    once_v[0] = 1'b1; in0_v[0] = 16'd7; in1_v[0] = 16'd0;
    @(negedge clk);
    once_v[0] = 1'b0;
    wait_done();
    repeat (40) @(negedge clk);

    // Reset in the middle of an operation: no done pulse, and every output clears
    issue(0, 16'd12345, 16'd11, 4'd3);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("abort_out", out_v[0], 0);
    check("abort_rem", rem_v[0], 0);
    check("abort_flags", {done_v[0], busy_v[0], dz_v[0], ovf_v[0]}, 0);
    repeat (40) @(negedge clk);

    // Random back-to-back operations on both instances
    for (int i = 0; i < 60; i++) begin
      rs = 1'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 16'h0000;
        1:       rb = 16'h8000;
        2, 3:    rb = 16'($urandom_range(1, 15));
        default: rb = 16'($urandom);
      endcase
      ra  = ($urandom_range(0, 9) == 0) ? 16'h8000 : 16'($urandom);
      rsh = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      run(rs, ra, rb, rsh);
    end
    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
